// File: rtl/conv1_pixel_streamer.sv
// rtl/conv1_pixel_streamer.sv - Conv1 input gearbox and frame sequencer (bus words -> pixels)
// Optional: `define CONV1_STREAMER_EOL_EN adds pix_eol/pix_eof row/frame markers.
module conv1_pixel_streamer #(
    parameter int pDATA_WIDTH   = 8,
    parameter int pIN_CHANNEL   = 3,
    parameter int pINPUT_WIDTH  = 224,
    parameter int pINPUT_HEIGHT = 224,
    parameter int pBUS_WIDTH    = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [pBUS_WIDTH-1:0]                s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic                                 dst_ready,
    output logic [pDATA_WIDTH*pIN_CHANNEL-1:0]   pix_data,
    output logic                                 pix_en,
    output logic                                 frame_done,
    output logic                                 busy
`ifdef CONV1_STREAMER_EOL_EN
    ,
    output logic                                 pix_eol,
    output logic                                 pix_eof
`endif
);

    localparam int PIX_W  = pDATA_WIDTH * pIN_CHANNEL;
    localparam int TOTAL  = pINPUT_WIDTH * pINPUT_HEIGHT;
    localparam int BUF_W  = 2 * pBUS_WIDTH;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int CNT_W  = $clog2(TOTAL + 1);

    if (PIX_W > pBUS_WIDTH) begin : g_cfg_check
        $error("conv1_pixel_streamer: pixel wider than bus word");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BUF_W-1:0]     sbuf_q, sbuf_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0]     pix_cnt_q;
    logic [BUF_W-1:0]     word_ext;
    logic                 cnt_done;
    logic                 emit;
    logic                 accept;
    logic                 last_emit;
    logic                 frame_start;

    assign word_ext    = {{(BUF_W - pBUS_WIDTH){1'b0}}, s_data};
    assign cnt_done    = (pix_cnt_q == CNT_W'(TOTAL));
    assign frame_start = (state_q == IDLE) && start;

    // Counter reaching TOTAL also closes s_ready so the next frame's first word is never swallowed.
    assign s_ready   = (state_q == STREAM) && !cnt_done
                       && (fill_q <= FILL_W'(BUF_W - pBUS_WIDTH));
    assign accept    = s_valid && s_ready;
    assign emit      = (state_q == STREAM) && !cnt_done
                       && (fill_q >= FILL_W'(PIX_W)) && dst_ready;
    assign last_emit = emit && (pix_cnt_q == CNT_W'(TOTAL - 1));

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (cnt_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gearbox: the word lands just above the bits still valid after this edge's pixel leaves.
    always_comb begin
        sbuf_d = sbuf_q;
        fill_d = fill_q;
        if (emit && accept) begin
            sbuf_d = (sbuf_q >> PIX_W) | (word_ext << (fill_q - FILL_W'(PIX_W)));
            fill_d = fill_q + FILL_W'(pBUS_WIDTH - PIX_W);
        end else if (emit) begin
            sbuf_d = sbuf_q >> PIX_W;
            fill_d = fill_q - FILL_W'(PIX_W);
        end else if (accept) begin
            sbuf_d = sbuf_q | (word_ext << fill_q);
            fill_d = fill_q + FILL_W'(pBUS_WIDTH);
        end
        if (last_emit) begin
            sbuf_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbuf_q    <= '0;
            fill_q    <= '0;
            pix_cnt_q <= '0;
            pix_data  <= '0;
            pix_en    <= 1'b0;
        end else begin
            if (frame_start) begin
                sbuf_q    <= '0;
                fill_q    <= '0;
                pix_cnt_q <= '0;
            end else begin
                sbuf_q <= sbuf_d;
                fill_q <= fill_d;
                if (emit) begin
                    pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                end
            end
            pix_en <= emit;
            if (emit) begin
                pix_data <= sbuf_q[PIX_W-1:0];
            end
        end
    end

`ifdef CONV1_STREAMER_EOL_EN
    localparam int COL_W = $clog2(pINPUT_WIDTH + 1);

    logic [COL_W-1:0] col_q;
    logic             col_last;

    assign col_last = (col_q == COL_W'(pINPUT_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            pix_eol <= 1'b0;
            pix_eof <= 1'b0;
        end else begin
            if (frame_start) begin
                col_q <= '0;
            end else if (emit) begin
                col_q <= col_last ? '0 : col_q + COL_W'(1);
            end
            pix_eol <= emit && col_last;
            pix_eof <= last_emit;
        end
    end
`endif

endmodule

// File: tb/tb_conv1_pixel_streamer.sv
// tb/tb_conv1_pixel_streamer.sv - directed self-checking bench for conv1_pixel_streamer
module tb_conv1_pixel_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        dst_ready;
    logic        start, s_valid, s_ready, pix_en, frame_done, busy;
    logic [63:0] s_data;
    logic [23:0] pix_data;
    logic        start5, s_valid5, s_ready5, pix_en5, frame_done5, busy5;
    logic [63:0] s_data5;
    logic [23:0] pix_data5;
`ifdef CONV1_STREAMER_EOL_EN
    logic        pix_eol, pix_eof, pix_eol5, pix_eof5;
`endif

    always #5 clk = ~clk;

    conv1_pixel_streamer #(.pINPUT_WIDTH(4), .pINPUT_HEIGHT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .dst_ready(dst_ready), .pix_data(pix_data), .pix_en(pix_en),
        .frame_done(frame_done), .busy(busy)
`ifdef CONV1_STREAMER_EOL_EN
        , .pix_eol(pix_eol), .pix_eof(pix_eof)
`endif
    );

    conv1_pixel_streamer #(.pINPUT_WIDTH(5), .pINPUT_HEIGHT(1)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .s_data(s_data5), .s_valid(s_valid5),
        .s_ready(s_ready5), .dst_ready(dst_ready), .pix_data(pix_data5), .pix_en(pix_en5),
        .frame_done(frame_done5), .busy(busy5)
`ifdef CONV1_STREAMER_EOL_EN
        , .pix_eol(pix_eol5), .pix_eof(pix_eof5)
`endif
    );

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] pq[$];
    int          en_cyc[$];
    logic [23:0] pq5[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          done_cnt5 = 0;
`ifdef CONV1_STREAMER_EOL_EN
    logic        eol_q[$];
    logic        eof_q[$];
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_en) begin
            pq.push_back(pix_data);
            en_cyc.push_back(cyc);
`ifdef CONV1_STREAMER_EOL_EN
            eol_q.push_back(pix_eol);
            eof_q.push_back(pix_eof);
`endif
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (pix_en5) pq5.push_back(pix_data5);
        if (frame_done5) done_cnt5 = done_cnt5 + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] frame8(input logic [23:0] base);
        logic [191:0] f;
        for (int i = 0; i < 8; i++) f[i*24 +: 24] = base + 24'(24'h111111 * i);
        return f;
    endfunction

    function automatic logic [127:0] frame5(input logic [23:0] base);
        logic [127:0] f;
        f[127:120] = 8'hEE;
        for (int i = 0; i < 5; i++) f[i*24 +: 24] = base + 24'(24'h010203 * i);
        return f;
    endfunction

    task automatic pulse_start(input int which);
        @(posedge clk); #1;
        if (which == 0) start = 1'b1; else start5 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start5 = 1'b0;
    endtask

    task automatic send(input int which, input logic [63:0] w, output int acc_cyc);
        bit acc = 1'b0;
        if (which == 0) begin s_data = w; s_valid = 1'b1; end
        else begin s_data5 = w; s_valid5 = 1'b1; end
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if ((which == 0) ? s_ready : s_ready5) acc = 1'b1;
            @(posedge clk); #1;
        end
        acc_cyc = cyc;
        if (which == 0) s_valid = 1'b0; else s_valid5 = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    task automatic wait_done(input int which, input int target, input string tag);
        int i = 0;
        while (((which == 0) ? done_cnt : done_cnt5) < target && i < 400) begin
            @(posedge clk); #1;
            i++;
        end
        check(tag, ((which == 0) ? done_cnt : done_cnt5) >= target, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame8(input string tag, input int b, input logic [191:0] f);
        check({tag, "_count"}, pq.size() - b, 8);
        for (int i = 0; i < 8; i++) begin
            if (b + i < pq.size()) begin
                check($sformatf("%s_px%0d", tag, i), pq[b+i], f[i*24 +: 24]);
`ifdef CONV1_STREAMER_EOL_EN
                check($sformatf("%s_eol%0d", tag, i), eol_q[b+i], (i % 4) == 3);
                check($sformatf("%s_eof%0d", tag, i), eof_q[b+i], i == 7);
`endif
            end
        end
    endtask

    task automatic check_frame5(input string tag, input int b, input logic [127:0] f);
        check({tag, "_count"}, pq5.size() - b, 5);
        for (int i = 0; i < 5; i++) begin
            if (b + i < pq5.size()) check($sformatf("%s_px%0d", tag, i), pq5[b+i], f[i*24 +: 24]);
        end
    endtask

    initial begin
        int           b, d, a0, a1, a2;
        logic [191:0] f;
        logic [127:0] g;

        rst = 1'b1; dst_ready = 1'b1;
        start = 1'b0; s_valid = 1'b0; s_data = '0;
        start5 = 1'b0; s_valid5 = 1'b0; s_data5 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset: no acceptance even with a waiting source
        s_valid = 1'b1; s_valid5 = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_s_ready", s_ready, 0);
        check("idle_s_ready5", s_ready5, 0);
        check("idle_pix_en", pix_en, 0);
        check("idle_pix_data", pix_data, 0);
        check("idle_busy", busy, 0);
        check("idle_frame_done", frame_done, 0);
        s_valid = 1'b0; s_valid5 = 1'b0;

        // full rate
        f = frame8(24'h000000);
        b = pq.size(); d = done_cnt;
        pulse_start(0);
        check("t2_busy", busy, 1);
        send(0, f[63:0], a0);
        send(0, f[127:64], a1);
        send(0, f[191:128], a2);
        wait_done(0, d + 1, "t2_done_seen");
        check_frame8("t2", b, f);
        if (pq.size() >= b + 8) begin
            check("t2_latency", en_cyc[b], a0 + 1);
            check("t2_rate", en_cyc[b+7] - en_cyc[b], 7);
            check("t2_done_align", done_cyc, en_cyc[b+7] + 1);
        end
        check("t2_done_once", done_cnt, d + 1);
        check("t2_busy_end", busy, 0);

        // backpressure
        b = pq.size(); d = done_cnt;
        dst_ready = 1'b0;
        pulse_start(0);
        send(0, f[63:0], a0);
        check("t3_ready_fill64", s_ready, 1);
        send(0, f[127:64], a1);
        check("t3_ready_fill128", s_ready, 0);
        check("t3_no_emit", pq.size() - b, 0);
        fork
            send(0, f[191:128], a2);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    dst_ready = ~dst_ready;
                end
                dst_ready = 1'b1;
            end
        join
        wait_done(0, d + 1, "t3_done_seen");
        check_frame8("t3", b, f);
        check("t3_done_once", done_cnt, d + 1);

        // source stall
        b = pq.size(); d = done_cnt;
        pulse_start(0);
        send(0, f[63:0], a0);
        repeat (5) @(posedge clk);
        #1;
        send(0, f[127:64], a1);
        repeat (5) @(posedge clk);
        #1;
        send(0, f[191:128], a2);
        wait_done(0, d + 1, "t4_done_seen");
        check_frame8("t4", b, f);
        if (pq.size() >= b + 8) check("t4_gaps", (en_cyc[b+7] - en_cyc[b]) > 7, 1);

        // start while busy is ignored
        b = pq.size(); d = done_cnt;
        pulse_start(0);
        send(0, f[63:0], a0);
        pulse_start(0);
        send(0, f[127:64], a1);
        send(0, f[191:128], a2);
        wait_done(0, d + 1, "t6_done_seen");
        check_frame8("t6", b, f);
        check("t6_done_once", done_cnt, d + 1);

        // asynchronous reset while pixel 3 is on the output
        b = pq.size(); d = done_cnt;
        pulse_start(0);
        send(0, f[63:0], a0);
        send(0, f[127:64], a1);
        for (int i = 0; i < 100 && pq.size() < b + 4; i++) begin
            @(negedge clk); #1;
        end
        check("t6_px3_seen", pq.size() >= b + 4, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_pix_en", pix_en, 0);
        check("t6_rst_pix_data", pix_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_s_ready", s_ready, 0);
        check("t6_rst_frame_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        b = pq.size();
        pulse_start(0);
        send(0, f[63:0], a0);
        send(0, f[127:64], a1);
        send(0, f[191:128], a2);
        wait_done(0, d + 1, "t6_fresh_done_seen");
        check_frame8("t6_fresh", b, f);
        check("t6_fresh_done_once", done_cnt, d + 1);

        // residual bits of the last word are discarded
        g = frame5(24'hA10000);
        b = pq5.size(); d = done_cnt5;
        pulse_start(1);
        send(1, g[63:0], a0);
        send(1, g[127:64], a1);
        wait_done(1, d + 1, "t5_done_seen");
        check_frame5("t5", b, g);
        check("t5_s_ready_idle", s_ready5, 0);
        g = frame5(24'h5B0000);
        b = pq5.size();
        pulse_start(1);
        send(1, g[63:0], a0);
        send(1, g[127:64], a1);
        wait_done(1, d + 2, "t5b_done_seen");
        check_frame5("t5b", b, g);
        check("t5b_done_count", done_cnt5, d + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
